outbuf_vc_fifo: RTL and testbench

Parametrised per-virtual-channel output buffer for the router output port: each of `NUM_VC` virtual channels owns a `DEPTH`-entry FIFO of `DATA_W`-bit flits. The internal crossbar enqueues into a selected VC. The external link drains the VC named by `tx_vc` under the `so`/`ro` handshake. It is the multi-entry, multi-VC generalisation of the single-flit output cell; it adds back-to-back throughput, an explicit ready signal and overflow reporting.

---
 rtl/outbuf_vc_fifo.sv | 134 +++++++++++++
 tb/tb_outbuf_vc_fifo.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outbuf_vc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : outbuf_vc_fifo
// Brief    : Per-virtual-channel output buffer. Each VC owns a DEPTH-entry FIFO.
//            The crossbar enqueues into enq_vc, and the link drains tx_vc under so/ro.
// Revision : 1.0 - initial release
// ============================================================================
module outbuf_vc_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int NUM_VC = 2,
  parameter int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enq,
  input  logic [VC_W-1:0]         enq_vc,
  input  logic [DATA_W-1:0]       d_in,
  output logic                    enq_ready,
  input  logic [VC_W-1:0]         tx_vc,
  input  logic                    ro,
  output logic                    so,
  output logic [DATA_W-1:0]       d_out,
  output logic [NUM_VC-1:0]       full,
  output logic [NUM_VC-1:0]       empty,
  output logic [NUM_VC*CNT_W-1:0] count,
  output logic [NUM_VC-1:0]       ovf
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
  endfunction

  logic [NUM_VC-1:0]             w_full;
  logic [NUM_VC-1:0]             w_empty;
  logic [NUM_VC-1:0]             w_tx_sel;
  logic [NUM_VC-1:0]             w_enq_sel;
  logic [NUM_VC-1:0][DATA_W-1:0] w_head;
  logic                          w_tx_empty;
  logic                          w_enq_full;
  logic                          w_enq_valid;
  logic [DATA_W-1:0]             w_tx_head;
  logic                          w_deq;
  logic                          w_acc;
  logic                          w_rej;

  // An out-of-range VC index matches no select line, so it reads as empty on the
  // send side and as full on the enqueue side.
  always_comb begin
    w_tx_empty  = 1'b1;
    w_tx_head   = '0;
    w_enq_full  = 1'b1;
    w_enq_valid = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_tx_sel[v]) begin
        w_tx_empty = w_empty[v];
        w_tx_head  = w_head[v];
      end
      if (w_enq_sel[v]) begin
        w_enq_full  = w_full[v];
        w_enq_valid = 1'b1;
      end
    end
  end

  assign so        = ro & ~w_tx_empty;
  assign d_out     = w_tx_empty ? '0 : w_tx_head;
  assign w_deq     = so;
  // A full VC still accepts when its head leaves on the same edge.
  assign enq_ready = ~w_enq_full | (w_deq & (tx_vc == enq_vc));
  assign w_acc     = enq & enq_ready;
  assign w_rej     = enq & ~enq_ready & w_enq_valid;

  assign full  = w_full;
  assign empty = w_empty;

  generate
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      logic [c_ptr_w-1:0] r_rdptr;
      logic [c_ptr_w-1:0] r_wrptr;
      logic [CNT_W-1:0]   r_count;
      logic               r_ovf;
      logic [DATA_W-1:0]  r_mem [DEPTH];
      logic               w_acc_v;
      logic               w_deq_v;

      assign w_tx_sel[v]  = (tx_vc == VC_W'(v));
      assign w_enq_sel[v] = (enq_vc == VC_W'(v));
      assign w_acc_v      = w_acc & w_enq_sel[v];
      assign w_deq_v      = w_deq & w_tx_sel[v];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_rdptr <= '0;
          r_wrptr <= '0;
          r_count <= '0;
          r_ovf   <= 1'b0;
        end else begin
          if (w_acc_v) begin
            r_wrptr <= f_ptr_inc(r_wrptr);
          end
          if (w_deq_v) begin
            r_rdptr <= f_ptr_inc(r_rdptr);
          end
          if (w_acc_v && !w_deq_v) begin
            r_count <= r_count + CNT_W'(1);
          end else if (!w_acc_v && w_deq_v) begin
            r_count <= r_count - CNT_W'(1);
          end
          if (w_rej && w_enq_sel[v]) begin
            r_ovf <= 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (w_acc_v) begin
          r_mem[r_wrptr] <= d_in;
        end
      end

      assign w_head[v]                = r_mem[r_rdptr];
      assign w_full[v]                = (r_count == CNT_W'(DEPTH));
      assign w_empty[v]               = (r_count == '0);
      assign count[v*CNT_W +: CNT_W]  = r_count;
      assign ovf[v]                   = r_ovf;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_outbuf_vc_fifo.sv
`default_nettype none
// Bench for outbuf_vc_fifo: a DEPTH=2 and a DEPTH=3 instance share stimulus.
// Both instances are compared every cycle against a queue-based model.
module tb_outbuf_vc_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        enq;
  logic        enq_vc;
  logic [63:0] d_in;
  logic        tx_vc;
  logic        ro;

  logic        enq_ready2, so2, enq_ready3, so3;
  logic [63:0] do2, do3;
  logic [1:0]  full2, empty2, ovf2, full3, empty3, ovf3;
  logic [3:0]  count2, count3;

  int n_err    = 0;
  int n_checks = 0;

  logic [63:0] mq [2][2][$];
  logic        movf [2][2];
  logic [63:0] got [$];

  always #5 clk = ~clk;

  outbuf_vc_fifo #(.DATA_W(64), .DEPTH(2), .NUM_VC(2)) dut2 (
    .clk(clk), .reset(reset), .enq(enq), .enq_vc(enq_vc), .d_in(d_in),
    .enq_ready(enq_ready2), .tx_vc(tx_vc), .ro(ro), .so(so2), .d_out(do2),
    .full(full2), .empty(empty2), .count(count2), .ovf(ovf2)
  );

  outbuf_vc_fifo #(.DATA_W(64), .DEPTH(3), .NUM_VC(2)) dut3 (
    .clk(clk), .reset(reset), .enq(enq), .enq_vc(enq_vc), .d_in(d_in),
    .enq_ready(enq_ready3), .tx_vc(tx_vc), .ro(ro), .so(so3), .d_out(do3),
    .full(full3), .empty(empty3), .count(count3), .ovf(ovf3)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  // Outputs implied by the queue contents and the current inputs.
  function automatic void model_outs(input int d, output logic so_e,
                                     output logic [63:0] do_e, output logic rdy_e);
    int tv = int'(tx_vc);
    int ev = int'(enq_vc);
    so_e = 1'b0;
    do_e = '0;
    if (mq[d][tv].size() > 0) begin
      do_e = mq[d][tv][0];
      so_e = ro;
    end
    rdy_e = (mq[d][ev].size() < depth_of(d)) || (so_e && (tv == ev));
  endfunction

  function automatic void compare(input int d);
    logic        so_e, rdy_e;
    logic [63:0] do_e;
    logic [1:0]  ef, ee, eo;
    logic [3:0]  ec;
    string       p;
    p = $sformatf("depth%0d", depth_of(d));
    model_outs(d, so_e, do_e, rdy_e);
    for (int v = 0; v < 2; v++) begin
      ef[v]         = (mq[d][v].size() == depth_of(d));
      ee[v]         = (mq[d][v].size() == 0);
      ec[v*2 +: 2]  = 2'(mq[d][v].size());
      eo[v]         = movf[d][v];
    end
    chk({p, "_so"},        (d == 0) ? so2        : so3,        so_e);
    chk({p, "_do"},        (d == 0) ? do2        : do3,        do_e);
    chk({p, "_enq_ready"}, (d == 0) ? enq_ready2 : enq_ready3, rdy_e);
    chk({p, "_full"},      (d == 0) ? full2      : full3,      ef);
    chk({p, "_empty"},     (d == 0) ? empty2     : empty3,     ee);
    chk({p, "_count"},     (d == 0) ? count2     : count3,     ec);
    chk({p, "_ovf"},       (d == 0) ? ovf2       : ovf3,       eo);
  endfunction

  initial begin
    for (int d = 0; d < 2; d++)
      for (int v = 0; v < 2; v++)
        movf[d][v] = 1'b0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int d = 0; d < 2; d++)
          for (int v = 0; v < 2; v++) begin
            mq[d][v].delete();
            movf[d][v] = 1'b0;
          end
      end else begin
        for (int d = 0; d < 2; d++) begin
          logic so_e, rdy_e;
          logic [63:0] do_e;
          model_outs(d, so_e, do_e, rdy_e);
          if (so_e) void'(mq[d][int'(tx_vc)].pop_front());
          if (enq) begin
            if (rdy_e) mq[d][int'(enq_vc)].push_back(d_in);
            else       movf[d][int'(enq_vc)] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      compare(0);
      compare(1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    logic seen_full;
    reset = 1'b0; enq = 1'b0; enq_vc = 1'b0; d_in = '0; tx_vc = 1'b0; ro = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", empty2, 2'b11);
    chk("rst_full", full2, 2'b00);
    chk("rst_so", so2, 1'b0);
    chk("rst_do", do2, 64'h0);
    chk("rst_enq_ready", enq_ready2, 1'b1);
    tick();
    reset = 1'b1;

    // Fill VC0 with ro low, then drain it.
    enq = 1'b1; enq_vc = 1'b0; d_in = 64'h1111;
    tick();
    d_in = 64'h2222;
    tick();
    enq = 1'b0;
    @(negedge clk);
    chk("fill_full0", full2[0], 1'b1);
    chk("fill_count0", count2[1:0], 2'd2);
    chk("fill_so", so2, 1'b0);
    tick();
    ro = 1'b1; tx_vc = 1'b0;
    @(negedge clk);
    chk("drain_so", so2, 1'b1);
    chk("drain_do0", do2, 64'h1111);
    tick();
    @(negedge clk);
    chk("drain_do1", do2, 64'h2222);
    tick();
    @(negedge clk);
    chk("drain_empty0", empty2[0], 1'b1);
    chk("drain_so_end", so2, 1'b0);
    tick();
    ro = 1'b0;

    // Overflow on VC1.
    enq = 1'b1; enq_vc = 1'b1; d_in = 64'h0A01;
    tick();
    d_in = 64'h0A02;
    tick();
    d_in = 64'hDEAD;
    @(negedge clk);
    chk("ovf_enq_ready", enq_ready2, 1'b0);
    tick();
    enq = 1'b0;
    @(negedge clk);
    chk("ovf_flag1", ovf2[1], 1'b1);
    chk("ovf_count1", count2[3:2], 2'd2);
    tick();
    tx_vc = 1'b1; ro = 1'b1;
    @(negedge clk);
    chk("ovf_drain0", do2, 64'h0A01);
    tick();
    @(negedge clk);
    chk("ovf_drain1", do2, 64'h0A02);
    tick();
    @(negedge clk);
    chk("ovf_no_dead", so2, 1'b0);
    chk("ovf_deep_dead", do3, 64'hDEAD);
    tick();
    ro = 1'b0; tx_vc = 1'b0;

    // Full VC0 with simultaneous enqueue and dequeue.
    enq = 1'b1; enq_vc = 1'b0; d_in = 64'h0C0A;
    tick();
    d_in = 64'h0C0B;
    tick();
    d_in = 64'h0C0C; ro = 1'b1;
    @(negedge clk);
    chk("fs_enq_ready", enq_ready2, 1'b1);
    chk("fs_do_a", do2, 64'h0C0A);
    tick();
    enq = 1'b0;
    @(negedge clk);
    chk("fs_count", count2[1:0], 2'd2);
    chk("fs_do_b", do2, 64'h0C0B);
    tick();
    @(negedge clk);
    chk("fs_do_c", do2, 64'h0C0C);
    tick();
    @(negedge clk);
    chk("fs_empty", empty2[0], 1'b1);
    tick();
    ro = 1'b0;

    // VC isolation.
    enq = 1'b1; enq_vc = 1'b0; d_in = 64'h5A5A;
    tick();
    enq = 1'b0; tx_vc = 1'b1; ro = 1'b1;
    @(negedge clk);
    chk("iso_so", so2, 1'b0);
    chk("iso_do", do2, 64'h0);
    chk("iso_count0", count2[1:0], 2'd1);
    tick();
    tx_vc = 1'b0;
    @(negedge clk);
    chk("iso_so_vc0", so2, 1'b1);
    chk("iso_do_vc0", do2, 64'h5A5A);
    tick();
    ro = 1'b0;

    // Ten flits through VC0 of the DEPTH=3 instance with stalls.
    sent = 0; seen_full = 1'b0; got.delete();
    enq_vc = 1'b0; tx_vc = 1'b0;
    for (int cyc = 0; cyc < 100 && got.size() < 10; cyc++) begin
      enq  = (sent < 10);
      d_in = 64'(256 + sent);
      ro   = ((cyc % 3) == 2);
      @(negedge clk);
      if (full3[0]) seen_full = 1'b1;
      if (enq && enq_ready3) sent++;
      if (so3) got.push_back(do3);
      tick();
    end
    enq = 1'b0; ro = 1'b0;
    chk("wrap_n_out", 64'(got.size()), 64'd10);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("wrap_seq%0d", i), got[i], 64'(256 + i));
    chk("wrap_reached_full", seen_full, 1'b1);

    // Asynchronous reset between edges with both VCs holding data.
    enq = 1'b1; enq_vc = 1'b0; d_in = 64'hAAAA;
    tick();
    enq_vc = 1'b1; d_in = 64'hBBBB;
    tick();
    enq = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_empty", empty2, 2'b11);
    chk("arst_so", so2, 1'b0);
    chk("arst_ovf", ovf2, 2'b00);
    chk("arst_count", count2, 4'd0);
    chk("arst_empty3", empty3, 2'b11);
    tick();
    reset = 1'b1;
    enq = 1'b1; enq_vc = 1'b1; d_in = 64'hF00D;
    tick();
    enq = 1'b0; tx_vc = 1'b1; ro = 1'b1;
    @(negedge clk);
    chk("post_rst_so", so2, 1'b1);
    chk("post_rst_do", do2, 64'hF00D);
    tick();
    @(negedge clk);
    chk("post_rst_empty", empty2, 2'b11);
    tick();
    ro = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
